// File: rtl/rv32i_wb_pkg.sv
// Shared types and default sizes for the RV32I write-back arbiter.
// The load-queue entry layout is fixed by the default widths below.
package rv32i_wb_pkg;

   localparam int XLEN_DEF     = 32;
   localparam int AW_DEF       = 5;
   localparam int LQ_DEPTH_DEF = 4;

   // Register x0 is hard-wired to zero and must never be written.
   localparam logic [AW_DEF-1:0] X0 = '0;

   // One buffered load response. live=0 means a younger ALU write to the
   // same register has superseded it; it still occupies a slot until popped.
   typedef struct packed {
      logic [AW_DEF-1:0]   rd;
      logic [XLEN_DEF-1:0] data;
      logic                live;
   } lq_entry_t;

endpackage

// File: rtl/rv32i_wb_lq.sv
// Circular load queue for the write-back arbiter. Supports one push and one
// pop per cycle plus a broadside kill that clears live on every entry whose
// rd matches kill_rd_i. push_killed_i enqueues an entry already superseded.
module rv32i_wb_lq
   import rv32i_wb_pkg::*;
#(
   parameter int DEPTH = LQ_DEPTH_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push_i,
   input  logic [AW_DEF-1:0]           push_rd_i,
   input  logic [XLEN_DEF-1:0]         push_data_i,
   input  logic                        push_killed_i,
   input  logic                        pop_i,
   input  logic                        kill_en_i,
   input  logic [AW_DEF-1:0]           kill_rd_i,
   output lq_entry_t                   head_o,
   output logic                        empty_o,
   output logic                        full_o,
   output logic [$clog2(DEPTH+1)-1:0]  count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   lq_entry_t         mem_q [DEPTH];
   logic [PW-1:0]     head_q;
   logic [PW-1:0]     tail_q;
   logic [CW-1:0]     count_q;

   // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of the others, independent of statement order.
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_i) tail_q <= tail_q + 1'b1;
         if (pop_i)  head_q <= head_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage: kill matching entries, then write the pushed entry.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; slots outside head..tail are
      // never observed, and resetting the pointers empties the queue.
      for (int i = 0; i < DEPTH; i++) begin
         if (kill_en_i && (mem_q[i].rd == kill_rd_i)) mem_q[i].live <= 1'b0;
      end
      if (push_i) begin
         mem_q[tail_q] <= '{rd: push_rd_i, data: push_data_i, live: !push_killed_i};
      end
   end

   assign head_o  = mem_q[head_q];
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;

endmodule

// File: rtl/rv32i_wb_arbiter.sv
// Register-file write-port arbiter for the RV32I core. ALU results always
// win; load responses are queued and retired in FIFO order in free cycles.
// An ALU write to rX kills older queued loads to rX, and x0 is never written.
// Optional macro RV32I_WB_BYPASS_EN: a load accepted while the queue is empty
// and the ALU is not writing goes straight to the write port.
module rv32i_wb_arbiter
   import rv32i_wb_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int AW       = AW_DEF,
   parameter int LQ_DEPTH = LQ_DEPTH_DEF
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           alu_valid,
   input  logic [AW-1:0]                  alu_rd,
   input  logic [XLEN-1:0]                alu_data,
   input  logic                           ld_valid,
   output logic                           ld_ready,
   input  logic [AW-1:0]                  ld_rd,
   input  logic [XLEN-1:0]                ld_data,
   output logic [AW-1:0]                  rd,
   output logic [XLEN-1:0]                din,
   output logic                           wen,
   output logic [$clog2(LQ_DEPTH+1)-1:0]  lq_count,
   output logic                           busy
);

   lq_entry_t       lq_head;
   logic            lq_empty;
   logic            lq_full;
   logic            ld_accept;
   logic            ld_live;
   logic            alu_wr;
   logic            bypass;
   logic            push;
   logic            pop;

   logic            wen_d, wen_q;
   logic [AW-1:0]   rd_d, rd_q;
   logic [XLEN-1:0] din_d, din_q;

   assign ld_ready  = !lq_full && !rst;
   assign ld_accept = ld_valid && ld_ready;
   assign ld_live   = ld_accept && (ld_rd != X0);
   assign alu_wr    = alu_valid && (alu_rd != X0);

`ifdef RV32I_WB_BYPASS_EN
   assign bypass = ld_live && lq_empty && !alu_wr;
`else
   assign bypass = 1'b0;
`endif

   // Loads to x0 and bypassed loads never occupy a slot.
   assign push = ld_live && !bypass;
   // The head retires only in ALU-idle cycles, live or killed.
   assign pop  = !alu_wr && !lq_empty;

   rv32i_wb_lq #(
      .DEPTH (LQ_DEPTH)
   ) u_lq (
      .clk           (clk),
      .rst           (rst),
      .push_i        (push),
      .push_rd_i     (ld_rd),
      .push_data_i   (ld_data),
      .push_killed_i (alu_wr && (alu_rd == ld_rd)),
      .pop_i         (pop),
      .kill_en_i     (alu_wr),
      .kill_rd_i     (alu_rd),
      .head_o        (lq_head),
      .empty_o       (lq_empty),
      .full_o        (lq_full),
      .count_o       (lq_count)
   );

   // Write-port priority: ALU, then live queue head, then bypassed load.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      wen_d = 1'b0;
      rd_d  = rd_q;
      din_d = din_q;
      if (alu_wr) begin
         wen_d = 1'b1;
         rd_d  = alu_rd;
         din_d = alu_data;
      end else if (pop && lq_head.live) begin
         wen_d = 1'b1;
         rd_d  = lq_head.rd;
         din_d = lq_head.data;
      end else if (bypass) begin
         wen_d = 1'b1;
         rd_d  = ld_rd;
         din_d = ld_data;
      end
   end

   // Registered write port; rd/din hold their last value while wen is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wen_q <= 1'b0;
         rd_q  <= '0;
         din_q <= '0;
      end else begin
         wen_q <= wen_d;
         rd_q  <= rd_d;
         din_q <= din_d;
      end
   end

   assign wen  = wen_q;
   assign rd   = rd_q;
   assign din  = din_q;
   assign busy = !lq_empty;

endmodule
